// File: rtl/sipo_deserializer_if.sv
// Serial-in and parallel-out handshake bundle for sipo_deserializer.
// The slave modport is the deserializer's view of the bundle; the master modport is the link/consumer side.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             sin_valid;
    logic             sin_data;
    logic             sin_sof;
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;

    modport slave (
        input  sin_valid,
        input  sin_data,
        input  sin_sof,
        input  par_ready,
        output par_data,
        output par_valid
    );

    modport master (
        output sin_valid,
        output sin_data,
        output sin_sof,
        output par_ready,
        input  par_data,
        input  par_valid
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: bit-valid qualified shift register, SOF realignment,
// single-entry holding register with valid/ready output, and sticky overrun/sync_err flags.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    sipo_deserializer_if.slave bus,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun,
    output logic          sync_err,
    input  logic          clear_err
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shift;
    logic             complete;
    logic             load;
    logic             overrun_set;
    logic             sync_set;
    logic             consume;

    // An SOF bit starts a fresh word: shift it into an empty register so it lands as bit 0.
    always_comb begin
        sr_base = bus.sin_sof ? '0 : sr;
        if (MSB_FIRST)
            sr_shift = {sr_base[WIDTH-2:0], bus.sin_data};
        else
            sr_shift = {bus.sin_data, sr_base[WIDTH-1:1]};
    end

    always_comb begin
        consume     = bus.par_valid && bus.par_ready;
        complete    = bus.sin_valid && !bus.sin_sof && (bit_cnt == LAST);
        load        = complete && (!bus.par_valid || bus.par_ready);
        overrun_set = complete && bus.par_valid && !bus.par_ready;
        sync_set    = bus.sin_valid && bus.sin_sof && (bit_cnt != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (bus.sin_valid) begin
            sr <= sr_shift;
            if (bus.sin_sof)
                bit_cnt <= CW'(1);
            else if (complete)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.par_data  <= '0;
            bus.par_valid <= 1'b0;
        end else if (load) begin
            bus.par_data  <= sr_shift;
            bus.par_valid <= 1'b1;
        end else if (consume) begin
            bus.par_valid <= 1'b0;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            overrun  <= overrun_set | (overrun  & ~clear_err);
            sync_err <= sync_set    | (sync_err & ~clear_err);
        end
    end
endmodule
